cozy_muldiv: RTL and testbench
==============================

Name: cozy_muldiv

Overview:
Iterative 16-bit multiply/divide unit that sits beside cozy_alu in the cozy CPU datapath. It handles the operations cozy_alu cannot do in one cycle.
- Takes the same r1/r2 operand pair and returns out plus carry_out in the ALU's result/carry format.
- Uses a start/busy/done handshake so the sequencer can stall while it runs.
- Radix-2: one bit per clock.

Parameters:
WIDTH, 16, operand/result width; only 16 is supported and verified.
CNT_W, 5, iteration counter width; must hold the value WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while busy=0 and done=0
op  input  2  operation: 00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 MOD (remainder); all unsigned
r1  input  16  multiplicand / dividend; captured on the accepted start
r2  input  16  multiplier / divisor; captured on the accepted start
busy  output  1  high while iterating
done  output  1  one-cycle pulse: result valid
out  output  16  result; held from done until the next accepted start
carry_out  output  1  MUL: 1 if the high half is nonzero. MULH: 0. DIV/MOD: 1 on divide-by-zero, else 0.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, out=0, carry_out=0; counter and accumulators cleared. An in-flight operation is abandoned, and no done is produced for it.
- States:
  - IDLE -> RUN on start. Operands and op are latched; counter=0.
  - IDLE -> FIN directly if op is DIV/MOD and r2==0.
  - RUN -> RUN while counter < WIDTH-1, incrementing counter each cycle.
  - RUN -> FIN after the 16th RUN cycle.
  - FIN -> IDLE unconditionally.
- busy=1 exactly in RUN. done=1 exactly in FIN. out and carry_out update on the edge entering FIN.
- Latency:
  - Normal: start sampled at edge N, busy high for 16 cycles, done high in the 17th cycle after N. No inputs are accepted during that window.
  - Divide-by-zero: done in the cycle after start, with busy never asserted.
- start during RUN or FIN is ignored, not queued. start may be held high: after FIN there is one IDLE cycle, then a new acceptance.
- Operands are latched, so changes to r1/r2/op after acceptance have no effect.
- Multiply: shift-add into a 32-bit product register (P = P + (m[0] ? r1<<i : 0)). MUL out = P[15:0], carry_out = |P[31:16]. MULH out = P[31:16].
- Divide: restoring. Per cycle the remainder R is shifted left with the next dividend bit; if R >= r2, subtract and set the quotient bit. DIV out = quotient, MOD out = remainder.
- Divide-by-zero: DIV out=16'hFFFF, MOD out=r1; carry_out=1 in both cases.
- Arithmetic wraps modulo 2^16 (2^32 internally for the product). No signed handling.

Optional Feature:
COZY_MULDIV_EARLY_EXIT_EN.
- Defined: MUL/MULH leave RUN once the remaining multiplier bits are all zero.
  - RUN lasts max(1, msb_index(r2)+1) cycles; r2==0 gives 1 cycle.
  - done follows one cycle later.
  - DIV/MOD timing is unchanged.
- Undefined: all non-zero-divisor operations take exactly 16 RUN cycles. Results are identical either way; only timing differs.

Decomposition:
- Shared include cozy_defs.v holds:
  - op encodings (COZY_MD_MUL/MULH/DIV/MOD);
  - state encodings (IDLE/RUN/FIN);
  - the divide-by-zero result constant 16'hFFFF.
- One natural combinational sub-module, cozy_div_step: takes R, the next dividend bit and the divisor; returns the new R and the quotient bit.
- Multiply step stays inline.

Test Plan:
- MUL r1=16'h1234, r2=16'h0010 -> done 17 cycles after start, out=16'h2340, carry_out=1, busy high exactly 16 cycles. With EARLY_EXIT_EN: busy 5 cycles, done 6 cycles after start.
- MULH r1=16'hFFFF, r2=16'hFFFF -> out=16'hFFFE, carry_out=0. MUL on the same operands -> out=16'h0001, carry_out=1.
- DIV r1=16'h1000, r2=16'h0003 -> out=16'h0555, carry_out=0. MOD on the same operands -> out=16'h0001.
- DIV r1=16'h1234, r2=0 -> done the cycle after start, busy never high, out=16'hFFFF, carry_out=1. MOD on the same operands -> out=16'h1234, carry_out=1.
- Re-pulse start with r2 changed at cycle 5 of a MUL -> ignored; the result matches the original operands, and exactly one done pulse occurs.
- Assert rst at cycle 8 of a DIV -> busy, done, out and carry_out go to 0 immediately. No done pulse follows. A new DIV after release completes correctly.

Source files
------------

// File: rtl/cozy_muldiv_pkg.sv
// cozy_muldiv_pkg: op/state encodings and divide-by-zero constant for cozy_muldiv
package cozy_muldiv_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
  localparam logic [1:0] COZY_MD_MUL = 2'b00;
  localparam logic [1:0] COZY_MD_MULH = 2'b01;
  localparam logic [1:0] COZY_MD_DIV = 2'b10;
  localparam logic [1:0] COZY_MD_MOD = 2'b11;
  localparam logic [15:0] COZY_MD_DIV0_Q = 16'hFFFF;
endpackage

// File: rtl/cozy_div_step.sv
// cozy_div_step: one restoring-division step (shift in dividend bit, conditional subtract)
module cozy_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] r,
  input  logic             din,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nxt,
  output logic             q
);
  logic [WIDTH:0] sh, diff;
  always_comb begin
    sh = {r, din};
    diff = sh - {1'b0, d};
    q = sh >= {1'b0, d};
    r_nxt = q ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  end
endmodule

// File: rtl/cozy_muldiv.sv
// cozy_muldiv: iterative radix-2 unsigned mul/div; define COZY_MULDIV_EARLY_EXIT_EN to cut multiplies short
module cozy_muldiv
  import cozy_muldiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0] opr;
  logic [WIDTH-1:0] a, b, rem, rem_nxt, res;
  logic [2*WIDTH-1:0] p, p_nxt;
  logic qbit, is_mul, dz, last;
  assign is_mul = ~opr[1];
  assign dz = op[1] && r2 == '0;
  assign p_nxt = p + (b[0] ? {{WIDTH{1'b0}}, a} << cnt : '0);
  // a doubles as dividend shifter and quotient accumulator during divide
  cozy_div_step #(.WIDTH(WIDTH)) u_step (
    .r(rem),
    .din(a[WIDTH-1]),
    .d(b),
    .r_nxt(rem_nxt),
    .q(qbit)
  );
`ifdef COZY_MULDIV_EARLY_EXIT_EN
  assign last = cnt == CNT_W'(WIDTH-1) || (is_mul && b[WIDTH-1:1] == '0);
`else
  assign last = cnt == CNT_W'(WIDTH-1);
`endif
  assign res = opr == COZY_MD_MUL ? p_nxt[WIDTH-1:0] :
               opr == COZY_MD_MULH ? p_nxt[2*WIDTH-1:WIDTH] :
               opr == COZY_MD_DIV ? {a[WIDTH-2:0], qbit} : rem_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (start ? (dz ? FIN : RUN) : IDLE) :
                state == RUN ? (last ? FIN : RUN) : IDLE;
  end
  always_comb begin
    busy = state == RUN;
    done = state == FIN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      opr <= '0;
      a <= '0;
      b <= '0;
      p <= '0;
      rem <= '0;
      out <= '0;
      carry_out <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
      opr <= op;
      a <= r1;
      b <= r2;
      p <= '0;
      rem <= '0;
      if (dz) begin
        out <= op == COZY_MD_DIV ? COZY_MD_DIV0_Q : r1;
        carry_out <= 1'b1;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (is_mul) begin
        p <= p_nxt;
        b <= b >> 1;
      end else begin
        rem <= rem_nxt;
        a <= {a[WIDTH-2:0], qbit};
      end
      if (last) begin
        out <= res;
        carry_out <= opr == COZY_MD_MUL && |p_nxt[2*WIDTH-1:WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_cozy_muldiv.sv
// tb_cozy_muldiv: directed scoreboard bench for cozy_muldiv results, latency and reset
module tb_cozy_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [15:0] r1 = '0, r2 = '0;
  logic busy, done, carry_out;
  logic [15:0] out;
  int compared = 0;
  int mismatched = 0;
  logic [16:0] sb[$];
  cozy_muldiv dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .r1(r1),
    .r2(r2),
    .busy(busy),
    .done(done),
    .out(out),
    .carry_out(carry_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [16:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, b};
    case (o)
      2'b00: return {|p[31:16], p[15:0]};
      2'b01: return {1'b0, p[31:16]};
      2'b10: return b == 0 ? {1'b1, 16'hFFFF} : {1'b0, a / b};
      default: return b == 0 ? {1'b1, a} : {1'b0, a % b};
    endcase
  endfunction
  function automatic int exp_lat(input logic [1:0] o, input logic [15:0] b);
    int m;
    if (o[1] && b == 0) return 1;
    m = 1;
`ifdef COZY_MULDIV_EARLY_EXIT_EN
    if (!o[1]) begin
      for (int i = 0; i < 16; i++) if (b[i]) m = i + 1;
      return m + 1;
    end
`endif
    m = 16;
    return m + 1;
  endfunction
  task automatic run(input string tag, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input int poke);
    int lat, nb, nd, at;
    logic [16:0] e;
    @(negedge clk);
    op = o;
    r1 = a;
    r2 = b;
    start = 1'b1;
    sb.push_back(model(o, a, b));
    lat = exp_lat(o, b);
    nb = 0;
    nd = 0;
    at = 0;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        nd++;
        at = k;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({tag, " result"}, {15'd0, carry_out, out}, {15'd0, e});
        end
      end
      start = k == poke;
      if (k == poke) begin
        r1 = ~a;
        r2 = b + 16'd7;
        op = ~o;
      end
    end
    start = 1'b0;
    if (nd == 0 && sb.size() > 0) e = sb.pop_front();
    check({tag, " latency"}, at, lat);
    check({tag, " busy cycles"}, nb, lat - 1);
    check({tag, " done pulses"}, nd, 1);
  endtask
  initial begin
    int nd;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset out", {carry_out, out}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run("mul 1234x10", 2'b00, 16'h1234, 16'h0010, 0);
    run("mulh ffff", 2'b01, 16'hFFFF, 16'hFFFF, 0);
    run("mul ffff", 2'b00, 16'hFFFF, 16'hFFFF, 0);
    run("div 1000/3", 2'b10, 16'h1000, 16'h0003, 0);
    run("mod 1000/3", 2'b11, 16'h1000, 16'h0003, 0);
    run("div by 0", 2'b10, 16'h1234, 16'h0000, 0);
    run("mod by 0", 2'b11, 16'h1234, 16'h0000, 0);
    run("mul r2=0", 2'b00, 16'hBEEF, 16'h0000, 0);
    run("div small", 2'b10, 16'h0002, 16'hFFFF, 0);
    run("mul repoke", 2'b00, 16'h1234, 16'h0010, 5);
    run("div repoke", 2'b10, 16'hF00D, 16'h0013, 3);
    for (int i = 0; i < 4; i++)
      run("random", 2'($urandom_range(3)), 16'($urandom), 16'($urandom_range(1, 65535)), 0);
    // abort a divide mid-flight with async reset
    @(negedge clk);
    op = 2'b10;
    r1 = 16'hABCD;
    r2 = 16'h0007;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort out", {carry_out, out}, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort no done", nd, 0);
    run("div after reset", 2'b10, 16'h1000, 16'h0003, 0);
    check("scoreboard empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
